if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: owns the PC, issues word fetches to instruction memory over a req/ack handshake, and presents the fetched instruction plus its PC+4 to the IF/ID pipeline register. It is the producer for IF/ID. It honours the same `IF_ID_Write` stall and the same `zero`/`PCSrc` redirect qualification that IF/ID uses to flush. A redirect discards any in-flight or held instruction and refetches from the target. State updates on posedge `CLK`, so outputs are stable when IF/ID samples on negedge.

---
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 tb/tb_if_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module  : if_fetch_unit
// Purpose : MIPS instruction-fetch stage; PC, req/ack imem fetch, IF/ID feed.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IF_ID_Write,
  input  logic        zero,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchPC,
  input  logic [31:0] JumpPC,
  input  logic [31:0] JrPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] readIns,
  output logic [31:0] nextPC4,
  output logic        ins_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redir;
  logic [31:0] target;
  logic        ack_seen;

  always_comb begin
    redir    = IF_ID_Write & (((PCSrc == 2'b01) & zero) | PCSrc[1]);
    pc_plus4 = pc + 32'd4;
    ack_seen = imem_ack & imem_req;
    case (PCSrc)
      2'b01:   target = BranchPC;
      2'b10:   target = JumpPC;
      default: target = JrPC;
    endcase
    target = target & ~32'h3;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      ins_valid   <= 1'b0;
      readIns     <= 32'd0;
      nextPC4     <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          // req low only right after reset: nothing outstanding, any ack is stale
          if (!imem_req) begin
            imem_req <= 1'b1;
            if (redir) begin
              pc        <= target;
              imem_addr <= target;
            end else begin
              imem_addr <= pc;
            end
          end else if (redir) begin
            pc <= target;
            if (ack_seen) begin
              imem_addr <= target;
            end else begin
              state <= S_DRAIN;
            end
          end else if (ack_seen) begin
            readIns   <= imem_rdata;
            nextPC4   <= pc_plus4;
            ins_valid <= 1'b1;
            imem_req  <= 1'b0;
            state     <= S_VALID;
          end
        end

        S_VALID: begin
          if (redir) begin
            pc        <= target;
            imem_addr <= target;
            imem_req  <= 1'b1;
            ins_valid <= 1'b0;
            readIns   <= 32'd0;
            state     <= S_FETCH;
          end else if (IF_ID_Write) begin
            pc          <= pc_plus4;
            imem_addr   <= pc_plus4;
            imem_req    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            ins_valid   <= 1'b0;
            readIns     <= 32'd0;
            state       <= S_FETCH;
          end
        end

        S_DRAIN: begin
          // request must run to completion; the newest target is issued after it
          if (redir) begin
            pc <= target;
          end
          if (ack_seen) begin
            imem_addr <= redir ? target : pc;
            state     <= S_FETCH;
          end
        end

        default: begin
          state     <= S_FETCH;
          imem_req  <= 1'b0;
          ins_valid <= 1'b0;
          readIns   <= 32'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module  : tb_if_fetch_unit
// Purpose : Directed self-checking bench for if_fetch_unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IF_ID_Write;
  logic        zero;
  logic [1:0]  PCSrc;
  logic [31:0] BranchPC;
  logic [31:0] JumpPC;
  logic [31:0] JrPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] readIns;
  logic [31:0] nextPC4;
  logic        ins_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cnt    = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .IF_ID_Write (IF_ID_Write),
    .zero        (zero),
    .PCSrc       (PCSrc),
    .BranchPC    (BranchPC),
    .JumpPC      (JumpPC),
    .JrPC        (JrPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .readIns     (readIns),
    .nextPC4     (nextPC4),
    .ins_valid   (ins_valid),
    .fetch_count (fetch_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h2001_0005 : {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then the memory model reacts: ack arrives `lat` cycles
  // after the request first becomes visible.
  task automatic step();
    @(posedge CLK);
    #1;
    if (imem_ack) begin
      imem_ack = 1'b0;
      cnt      = 0;
    end
    if (!imem_req) begin
      cnt = 0;
    end else if (cnt == lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      cnt++;
    end
  endtask

  initial begin
    Reset = 1'b1; IF_ID_Write = 1'b1; zero = 1'b0; PCSrc = 2'b00;
    BranchPC = 32'd0; JumpPC = 32'd0; JrPC = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;

    // reset state
    step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_ins", readIns, 32'd0);
    chk("rst_pc4", nextPC4, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);

    // first fetch, 1-cycle latency memory
    Reset = 1'b0;
    step();
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    step();
    chk("c2_valid", {31'd0, ins_valid}, 32'd0);
    step();
    chk("c3_valid", {31'd0, ins_valid}, 32'd1);
    chk("c3_ins", readIns, 32'h2001_0005);
    chk("c3_pc4", nextPC4, 32'd4);
    chk("c3_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("acc_addr", imem_addr, 32'd4);
    chk("acc_req", {31'd0, imem_req}, 32'd1);
    chk("acc_cnt", fetch_count, 32'd1);
    chk("acc_ins0", readIns, 32'd0);
    step(); step();
    chk("w4_ins", readIns, 32'hA500_0004);
    chk("w4_pc4", nextPC4, 32'd8);

    // stall in VALID with PC=8; a redirect during stall must be ignored
    step(); step();
    IF_ID_Write = 1'b0;
    step();
    chk("st_ins", readIns, 32'hA500_0008);
    PCSrc = 2'b10; JumpPC = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_ins", readIns, 32'hA500_0008);
      chk("st_hold_pc4", nextPC4, 32'd12);
      chk("st_hold_vld", {31'd0, ins_valid}, 32'd1);
      chk("st_hold_req", {31'd0, imem_req}, 32'd0);
    end
    PCSrc = 2'b00; IF_ID_Write = 1'b1;
    step();
    chk("rel_addr", imem_addr, 32'd12);
    chk("rel_cnt", fetch_count, 32'd3);

    // branch taken while VALID
    step(); step();
    chk("b_pre_vld", {31'd0, ins_valid}, 32'd1);
    PCSrc = 2'b01; zero = 1'b1; BranchPC = 32'h40;
    step();
    chk("bt_addr", imem_addr, 32'h40);
    chk("bt_cnt", fetch_count, 32'd3);
    chk("bt_vld", {31'd0, ins_valid}, 32'd0);
    PCSrc = 2'b00; zero = 1'b0;
    step(); step();
    chk("bt_ins", readIns, 32'hA500_0040);
    chk("bt_pc4", nextPC4, 32'h44);

    // branch not taken -> sequential; the next fetch uses 4-cycle latency
    lat = 4;
    PCSrc = 2'b01; zero = 1'b0; BranchPC = 32'h80;
    step();
    chk("bn_addr", imem_addr, 32'h44);
    chk("bn_cnt", fetch_count, 32'd4);
    PCSrc = 2'b00;

    // jump in FETCH cycle 2 -> drain old request, then refetch at target
    step();
    PCSrc = 2'b10; JumpPC = 32'h100;
    step();
    PCSrc = 2'b00;
    chk("dr_addr0", imem_addr, 32'h44);
    chk("dr_req0", {31'd0, imem_req}, 32'd1);
    step();
    chk("dr_addr1", imem_addr, 32'h44);
    step();
    chk("dr_ack", {31'd0, imem_ack}, 32'd1);
    step();
    chk("dr_new_addr", imem_addr, 32'h100);
    chk("dr_vld", {31'd0, ins_valid}, 32'd0);
    chk("dr_cnt", fetch_count, 32'd4);

    // jr in the same cycle as the ack
    lat = 1;
    step();
    chk("jr_ack", {31'd0, imem_ack}, 32'd1);
    PCSrc = 2'b11; JrPC = 32'h203;
    step();
    PCSrc = 2'b00;
    chk("jr_addr", imem_addr, 32'h200);
    chk("jr_vld", {31'd0, ins_valid}, 32'd0);
    chk("jr_ins", readIns, 32'd0);
    step(); step();
    chk("jr_ins2", readIns, 32'hA500_0200);
    chk("jr_pc4", nextPC4, 32'h204);
    chk("jr_cnt", fetch_count, 32'd4);

    // reset while in DRAIN, late ack arrives the next cycle
    lat = 4;
    step();
    chk("rd_cnt", fetch_count, 32'd5);
    PCSrc = 2'b10; JumpPC = 32'h300;
    step();
    PCSrc = 2'b00;
    chk("rd_drain_addr", imem_addr, 32'h204);
    Reset = 1'b1; lat = 1;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    Reset = 1'b0;
    chk("rd_req", {31'd0, imem_req}, 32'd0);
    chk("rd_cnt0", fetch_count, 32'd0);
    step();
    chk("rd_late_vld", {31'd0, ins_valid}, 32'd0);
    chk("rd_late_addr", imem_addr, 32'd0);
    chk("rd_late_req", {31'd0, imem_req}, 32'd1);
    step(); step();
    chk("rd_re_vld", {31'd0, ins_valid}, 32'd1);
    chk("rd_re_ins", readIns, 32'h2001_0005);
    chk("rd_re_cnt", fetch_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
